wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Capture-side counterpart to the ImageFilter pipeline's write-back port. Each cycle the pipeline asserts its register-file write enable, the block timestamps the event (destination register, write data) and queues it in a FIFO. A bench, host link or debug reader drains the FIFO over a valid/ready handshake. It replaces hand-clocked waveform inspection of the write-back stage with an ordered, lossless-unless-full event stream.

## Interface
Parameters:
- DATA_W, 32, width of write-back data
- REG_W, 4, width of destination register index
- STAMP_W, 16, width of cycle timestamp
- DEPTH, 16, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cap_en  in  1  capture enable; when low, write-back events are ignored (not counted as drops)
- wb_we  in  1  write-back enable from pipeline WB stage
- wb_reg  in  REG_W  destination register of the write-back
- wb_data  in  DATA_W  value written back
- out_valid  out  1  FIFO head holds an entry
- out_ready  in  1  consumer accepts head this cycle
- out_reg  out  REG_W  head entry register
- out_data  out  DATA_W  head entry data
- out_stamp  out  STAMP_W  head entry timestamp
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one event dropped
- drop_cnt  out  8  dropped events, saturating at 255
- clr_ovf  in  1  clears overflow and drop_cnt

## Operation
- Capture: event = cap_en && wb_we in a cycle. Entry = {stamp_cnt, wb_reg, wb_data} sampled that cycle.
- stamp_cnt: free-running, 0 after reset, +1 every cycle, wraps 2^STAMP_W−1 → 0.
- Pop: out_valid && out_ready; head advances.
- Push accepted if level < DEPTH, or level == DEPTH with a pop in the same cycle (full + push + pop: level stays DEPTH, new entry queued).
- Push on full without pop: entry dropped, overflow ← 1, drop_cnt ← min(drop_cnt+1, 255).
- Push and pop on empty: level stays 0 after the cycle is impossible; push is written, pop not possible (out_valid=0), level → 1.
- Pointers DEPTH-modulo, wrap silently; level computed from push/pop, never from pointer difference alone.
- clr_ovf: overflow ← 0, drop_cnt ← 0; if a drop occurs in the same cycle, drop wins (overflow=1, drop_cnt=1).
- Output contents stable while out_valid && !out_ready.
- Reset mid-stream: all queued entries discarded, no partial pop.

## Timing
- Reset values: out_valid 0, level 0, overflow 0, drop_cnt 0, stamp_cnt 0; out_reg/out_data/out_stamp don't-care while out_valid=0 (bench must not check).
- Capture latency: event in cycle N → out_valid=1 with that entry at head in cycle N+1 (FIFO empty case).
- Pop in cycle N → next entry (if any) at head in N+1; back-to-back pops sustain 1 entry/cycle.
- level reflects pushes/pops of cycle N from N+1.
- Throughput: 1 capture and 1 pop per cycle simultaneously.

## Structure
- Shared package wb_trace_pkg: parameter defaults, entry struct typedef (stamp, reg, data), ENTRY_W constant.
- Sub-module sync_fifo (parameterised width/depth, registered pointers, distributed-RAM storage, combinational head read, full/empty/level outputs); wb_trace_buffer adds stamp counter, capture gating, drop/overflow logic.
- Expected size ≈150–250 lines total.

## Test plan
- Reset, then wb_we=1 reg=3 data=0x0000_00AB at cycle 5 (cap_en=1, out_ready=0) → cycle 6: out_valid=1, out_reg=3, out_data=0xAB, out_stamp=5, level=1.
- 16 consecutive events (data 0..15) with out_ready=0, then a 17th → level=16, overflow=1, drop_cnt=1; draining yields data 0..15 in order, no 16.
- FIFO full, event + out_ready=1 same cycle → overflow stays 0, level stays 16, new entry last out.
- cap_en=0 with wb_we toggling 10 cycles → level=0, drop_cnt=0; stamp_cnt advanced by 10 (next captured stamp confirms).
- 300 drops with ready=0 → drop_cnt=255; clr_ovf=1 alone → overflow=0, drop_cnt=0; clr_ovf coincident with drop → overflow=1, drop_cnt=1.
- rst asserted with level=7 → next cycle level=0, out_valid=0, stamp of next capture counts from 0; stamp wrap at 0xFFFF→0x0000 checked over 65,537 cycles.

Source files
------------

// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the write-back trace capture block.
package wb_trace_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_W_DEF   = 4;
    localparam int STAMP_W_DEF = 16;
    localparam int DEPTH_DEF   = 16;

    localparam int ENTRY_W = STAMP_W_DEF + REG_W_DEF + DATA_W_DEF;

    // One captured write-back event at the default widths; field order
    // matches the packed word stored in the FIFO (stamp in the MSBs).
    typedef struct packed {
        logic [STAMP_W_DEF-1:0] stamp;
        logic [REG_W_DEF-1:0]   reg_idx;
        logic [DATA_W_DEF-1:0]  data;
    } trace_entry_t;

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Drain-side valid/ready stream carrying the FIFO head entry.
interface wb_trace_buffer_if #(
    parameter int REG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int STAMP_W = 16
) ();
    logic               out_valid;
    logic               out_ready;
    logic [REG_W-1:0]   out_reg;
    logic [DATA_W-1:0]  out_data;
    logic [STAMP_W-1:0] out_stamp;

    modport master (
        output out_valid,
        output out_reg,
        output out_data,
        output out_stamp,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_reg,
        input  out_data,
        input  out_stamp,
        output out_ready
    );
endinterface

// File: rtl/wb_trace_buffer_sync_fifo.sv
// Single-clock FIFO with registered pointers, unreset storage and a
// combinational head read. A push while full is taken only if a pop
// frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 52,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == LVL_W'(DEPTH));
    assign level   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage write; no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy tracked from accepted push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/wb_trace_buffer.sv
// Timestamps pipeline write-back events and queues them for a drain
// consumer; counts events lost to a full queue.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int STAMP_W = STAMP_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic                     wb_we,
    input  logic [REG_W-1:0]         wb_reg,
    input  logic [DATA_W-1:0]        wb_data,
    wb_trace_buffer_if.master        out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_ovf
);
    localparam int EW    = STAMP_W + REG_W + DATA_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [STAMP_W-1:0] stamp_cnt;
    logic [EW-1:0]      wr_entry;
    logic [EW-1:0]      head;
    logic               cap_evt;
    logic               pop;
    logic               full;
    logic               empty;
    logic               drop;

    assign cap_evt  = cap_en && wb_we;
    assign pop      = out.out_valid && out.out_ready;
    assign drop     = cap_evt && full && !pop;
    assign wr_entry = {stamp_cnt, wb_reg, wb_data};

    assign out.out_valid = !empty;
    assign out.out_stamp = head[EW-1 -: STAMP_W];
    assign out.out_reg   = head[DATA_W +: REG_W];
    assign out.out_data  = head[DATA_W-1:0];

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_evt),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Free-running cycle stamp, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) stamp_cnt <= '0;
        else     stamp_cnt <= stamp_cnt + 1'b1;
    end

    // Sticky drop flag and saturating counter; a drop in the clear cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench: queue scoreboard plus directed vector table.
module tb_wb_trace_buffer;
    import wb_trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en;
    logic        wb_we;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_ovf;

    wb_trace_buffer_if #(.REG_W(4), .DATA_W(32), .STAMP_W(16)) tr_if ();

    wb_trace_buffer #(
        .DATA_W (32), .REG_W (4), .STAMP_W (16), .DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap_en),
        .wb_we    (wb_we),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .out      (tr_if),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cap_en;
        logic        wb_we;
        logic [3:0]  reg_i;
        logic [31:0] data;
        logic        ready;
        logic        exp_valid;
        int          exp_level;
        logic        chk_head;
        logic [3:0]  exp_reg;
        logic [31:0] exp_data;
        logic [15:0] exp_stamp;
    } vec_t;

    vec_t         vecs [10];
    trace_entry_t m_q [$];
    logic         m_ovf;
    logic [7:0]   m_drop;
    logic [15:0]  m_stamp;
    bit           chk_on;
    int           n_checks = 0;
    int           n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare outputs against the model, advance the model by the inputs
    // currently driven, then move to the middle of the next cycle.
    task automatic cycle();
        trace_entry_t e;
        logic pop_m, drop_m;
        if (chk_on) begin
            chk("sb_valid", {31'd0, tr_if.out_valid}, {31'd0, m_q.size() != 0});
            chk("sb_level", {27'd0, level}, m_q.size());
            chk("sb_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("sb_drop_cnt", {24'd0, drop_cnt}, {24'd0, m_drop});
            if (m_q.size() != 0) begin
                chk("sb_stamp", {16'd0, tr_if.out_stamp}, {16'd0, m_q[0].stamp});
                chk("sb_reg", {28'd0, tr_if.out_reg}, {28'd0, m_q[0].reg_idx});
                chk("sb_data", tr_if.out_data, m_q[0].data);
            end
        end
        if (rst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_drop  = 8'd0;
            m_stamp = 16'd0;
        end else begin
            pop_m  = (m_q.size() != 0) && tr_if.out_ready;
            drop_m = 1'b0;
            e.stamp   = m_stamp;
            e.reg_idx = wb_reg;
            e.data    = wb_data;
            if (pop_m) void'(m_q.pop_front());
            if (cap_en && wb_we) begin
                if (m_q.size() < 16) m_q.push_back(e);
                else drop_m = 1'b1;
            end
            if (drop_m) begin
                m_ovf  = 1'b1;
                m_drop = clr_ovf ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
            end else if (clr_ovf) begin
                m_ovf  = 1'b0;
                m_drop = 8'd0;
            end
            m_stamp = m_stamp + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cap_en = 1'b1; wb_we = 1'b0; wb_reg = 4'd0; wb_data = 32'd0;
        tr_if.out_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic evt(input logic [3:0] r, input logic [31:0] d, input logic rdy);
        cap_en = 1'b1; wb_we = 1'b1; wb_reg = r; wb_data = d;
        tr_if.out_ready = rdy; clr_ovf = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            tr_if.out_ready = 1'b1;
            cycle();
        end
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] s0;

        vecs[0] = '{1'b1, 1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 0, 1'b0, 4'd0, 32'h0,  16'd0};
        vecs[1] = vecs[0];
        vecs[2] = vecs[0];
        vecs[3] = vecs[0];
        vecs[4] = vecs[0];
        vecs[5] = '{1'b1, 1'b1, 4'd3, 32'hAB,   1'b0, 1'b0, 0, 1'b0, 4'd0, 32'h0,  16'd0};
        vecs[6] = '{1'b1, 1'b0, 4'd0, 32'h0,    1'b0, 1'b1, 1, 1'b1, 4'd3, 32'hAB, 16'd5};
        vecs[7] = '{1'b1, 1'b1, 4'd7, 32'h1234, 1'b1, 1'b1, 1, 1'b1, 4'd3, 32'hAB, 16'd5};
        vecs[8] = '{1'b1, 1'b0, 4'd0, 32'h0,    1'b1, 1'b1, 1, 1'b1, 4'd7, 32'h1234, 16'd7};
        vecs[9] = '{1'b1, 1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 0, 1'b0, 4'd0, 32'h0,  16'd0};

        chk_on = 1'b0;
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk_on = 1'b1;

        // Vector table: reset state, first-capture latency, pass-through.
        for (int i = 0; i < 10; i++) begin
            cap_en = vecs[i].cap_en; wb_we = vecs[i].wb_we;
            wb_reg = vecs[i].reg_i;  wb_data = vecs[i].data;
            tr_if.out_ready = vecs[i].ready; clr_ovf = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'd0, tr_if.out_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_level", i), {27'd0, level}, vecs[i].exp_level);
            if (vecs[i].chk_head) begin
                chk($sformatf("vec%0d_reg", i), {28'd0, tr_if.out_reg}, {28'd0, vecs[i].exp_reg});
                chk($sformatf("vec%0d_data", i), tr_if.out_data, vecs[i].exp_data);
                chk($sformatf("vec%0d_stamp", i), {16'd0, tr_if.out_stamp}, {16'd0, vecs[i].exp_stamp});
            end
            cycle();
        end

        // Fill to 16, 17th event dropped, drain in order.
        for (int i = 0; i < 16; i++) begin evt(4'd1, i, 1'b0); cycle(); end
        evt(4'd1, 32'd16, 1'b0); cycle(); idle();
        chk("full_level", {27'd0, level}, 32'd16);
        chk("full_overflow", {31'd0, overflow}, 32'd1);
        chk("full_drop_cnt", {24'd0, drop_cnt}, 32'd1);
        drain(16);
        chk("drained_level", {27'd0, level}, 32'd0);
        chk("drained_valid", {31'd0, tr_if.out_valid}, 32'd0);
        clr_ovf = 1'b1; cycle(); idle();

        // Full with simultaneous push and pop: nothing lost.
        for (int i = 0; i < 16; i++) begin evt(4'd2, 32'h200 + i, 1'b0); cycle(); end
        evt(4'd9, 32'd100, 1'b1); cycle(); idle();
        chk("pp_full_level", {27'd0, level}, 32'd16);
        chk("pp_full_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            idle(); tr_if.out_ready = 1'b1;
            if (i == 15) chk("pp_last_out", tr_if.out_data, 32'd100);
            cycle();
        end
        idle();

        // Capture disabled: no queueing, no drops, stamp keeps running.
        s0 = m_stamp;
        for (int i = 0; i < 10; i++) begin
            cap_en = 1'b0; wb_we = i[0]; wb_reg = 4'd5; wb_data = i;
            tr_if.out_ready = 1'b0; clr_ovf = 1'b0;
            cycle();
        end
        chk("capoff_level", {27'd0, level}, 32'd0);
        chk("capoff_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        evt(4'd5, 32'h55, 1'b0); cycle(); idle();
        chk("capoff_stamp", {16'd0, tr_if.out_stamp}, {16'd0, s0 + 16'd10});
        drain(1);

        // Drop counter saturation and clear interactions.
        for (int i = 0; i < 16; i++) begin evt(4'd3, i, 1'b0); cycle(); end
        for (int i = 0; i < 300; i++) begin evt(4'd3, 32'hDEAD, 1'b0); cycle(); end
        idle();
        chk("sat_drop_cnt", {24'd0, drop_cnt}, 32'd255);
        chk("sat_overflow", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1; cycle(); idle();
        chk("clr_overflow", {31'd0, overflow}, 32'd0);
        chk("clr_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        evt(4'd3, 32'hBEEF, 1'b0); clr_ovf = 1'b1; cycle(); idle();
        chk("clrdrop_overflow", {31'd0, overflow}, 32'd1);
        chk("clrdrop_drop_cnt", {24'd0, drop_cnt}, 32'd1);

        // Reset mid-stream discards queued entries and restarts the stamp.
        do_reset();
        for (int i = 0; i < 7; i++) begin evt(4'd4, i, 1'b0); cycle(); end
        idle();
        chk("pre_rst_level", {27'd0, level}, 32'd7);
        do_reset();
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_valid", {31'd0, tr_if.out_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        evt(4'd6, 32'h66, 1'b0); cycle(); idle();
        chk("rst_stamp", {16'd0, tr_if.out_stamp}, 32'd0);
        drain(1);

        // Stamp wrap 0xFFFF -> 0x0000.
        for (int i = 0; i < 70000 && m_stamp != 16'hFFFF; i++) cycle();
        evt(4'd7, 32'hAA, 1'b0); cycle();
        evt(4'd7, 32'hBB, 1'b0); cycle();
        idle();
        chk("wrap_stamp_hi", {16'd0, tr_if.out_stamp}, 32'h0000FFFF);
        tr_if.out_ready = 1'b1; cycle(); idle();
        chk("wrap_stamp_lo", {16'd0, tr_if.out_stamp}, 32'h00000000);
        chk("wrap_data_lo", tr_if.out_data, 32'hBB);
        drain(1);
        chk("end_level", {27'd0, level}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
